// File: rtl/bcd2421_word_seq_if.sv
// Handshake bundle for the BCD-to-2421 word sequencer: word in over valid/ready,
// converted word out over valid/ready.
interface bcd2421_word_seq_if #(
  parameter int unsigned NDIG = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [4*NDIG-1:0] in_bcd;
  logic              out_valid;
  logic              out_ready;
  logic [4*NDIG-1:0] out_code;
  logic              out_err;

  modport master (
    output in_valid, in_bcd, out_ready,
    input  in_ready, out_valid, out_code, out_err
  );

  modport slave (
    input  in_valid, in_bcd, out_ready,
    output in_ready, out_valid, out_code, out_err
  );
endinterface

// File: rtl/bcd2421_word_seq.sv
// Multi-digit 8421 BCD to 2421 (Aiken) converter stepping one shared digit converter LSD first.
// Optional macro BCD2421_ERR_CHECK_EN: flags digits >9 on out_err and zeroes their slots.
module bcd2421_word_seq #(
  parameter int unsigned NDIG = 4
) (
  input  logic                clk,
  input  logic                rst,
  bcd2421_word_seq_if.slave   bus,
  output logic                busy
);

  localparam int unsigned IW = $clog2(NDIG);
  localparam logic [IW-1:0] LastIdx = IW'(NDIG - 1);

  typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

  state_e            state;
  logic [IW-1:0]     idx;
  logic [4*NDIG-1:0] word;
  logic [4*NDIG-1:0] code;
  logic              in_ready;
  logic              out_valid;
  logic [3:0]        dig;
  logic [3:0]        dig_code;
`ifdef BCD2421_ERR_CHECK_EN
  logic              dig_bad;
  logic              err;
`endif

  always_comb begin
    dig      = word[{idx, 2'b00} +: 4];
    dig_code = (dig < 4'd5) ? dig : dig + 4'd6;
`ifdef BCD2421_ERR_CHECK_EN
    dig_bad = (dig > 4'd9);
    if (dig_bad) dig_code = 4'd0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= StIdle;
      idx       <= '0;
      word      <= '0;
      code      <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
`ifdef BCD2421_ERR_CHECK_EN
      err       <= 1'b0;
`endif
    end else begin
      unique case (state)
        StIdle: begin
          if (bus.in_valid) begin
            word     <= bus.in_bcd;
            idx      <= '0;
            code     <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= StConv;
`ifdef BCD2421_ERR_CHECK_EN
            err      <= 1'b0;
`endif
          end
        end
        StConv: begin
          code[{idx, 2'b00} +: 4] <= dig_code;
`ifdef BCD2421_ERR_CHECK_EN
          if (dig_bad) err <= 1'b1;
`endif
          if (idx == LastIdx) begin
            idx       <= '0;
            out_valid <= 1'b1;
            state     <= StDone;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        StDone: begin
          // Handing the word over reopens the input on the same edge.
          if (bus.out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_code  = code;
`ifdef BCD2421_ERR_CHECK_EN
  assign bus.out_err   = err;
`else
  assign bus.out_err   = 1'b0;
`endif

endmodule

// File: tb/tb_bcd2421_word_seq.sv
// Directed bench for bcd2421_word_seq (NDIG=4) with hand-computed 2421 words.
module tb_bcd2421_word_seq;
  localparam int unsigned NDIG = 4;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  int   n_checks = 0;
  int   n_pass   = 0;

  bcd2421_word_seq_if #(.NDIG(NDIG)) bus ();

  bcd2421_word_seq #(.NDIG(NDIG)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept_word(input logic [15:0] bcd);
    bus.in_bcd   = bcd;
    bus.in_valid = 1'b1;
    check("in_ready_before_accept", bus.in_ready, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    check("busy_after_accept", busy, 1'b1);
    check("in_ready_low_conv", bus.in_ready, 1'b0);
  endtask

  // Accept already happened; out_valid must appear exactly NDIG edges later.
  task automatic wait_done();
    for (int i = 1; i < NDIG; i++) begin
      check("out_valid_early", bus.out_valid, 1'b0);
      tick();
    end
    check("out_valid_early", bus.out_valid, 1'b0);
    tick();
    check("out_valid_latency", bus.out_valid, 1'b1);
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("out_valid_drop", bus.out_valid, 1'b0);
    check("in_ready_back", bus.in_ready, 1'b1);
    check("busy_drop", busy, 1'b0);
  endtask

  task automatic run_word(input string tag, input logic [15:0] bcd, input logic [15:0] exp_code,
                          input logic exp_err);
    accept_word(bcd);
    wait_done();
    check({tag, "_code"}, bus.out_code, exp_code);
    check({tag, "_err"}, bus.out_err, exp_err);
    drain();
  endtask

  logic        exp_err_bad;
  int          acc_cyc[$];
  logic [15:0] outs[$];
  logic        fire;
  logic        take;

  initial begin
`ifdef BCD2421_ERR_CHECK_EN
    exp_err_bad = 1'b1;
`else
    exp_err_bad = 1'b0;
`endif
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_bcd    = '0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_code", bus.out_code, 16'h0000);
    check("rst_out_err", bus.out_err, 1'b0);
    check("rst_busy", busy, 1'b0);

    // Reset mid-CONV abandons the word.
    accept_word(16'h5678);
    tick();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("midrst_in_ready", bus.in_ready, 1'b1);
    check("midrst_out_valid", bus.out_valid, 1'b0);
    check("midrst_out_code", bus.out_code, 16'h0000);
    check("midrst_busy", busy, 1'b0);
    for (int i = 0; i < NDIG + 2; i++) begin
      tick();
      check("midrst_no_valid", bus.out_valid, 1'b0);
    end

    run_word("w1234", 16'h1234, 16'h1234, 1'b0);
    run_word("w5678", 16'h5678, 16'hBCDE, 1'b0);
    run_word("w9059", 16'h9059, 16'hF0BF, 1'b0);

    // Backpressure: output must hold while input side is disturbed.
    accept_word(16'h9876);
    bus.in_bcd = 16'h1111;
    wait_done();
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = ~bus.in_valid;
      bus.in_bcd   = bus.in_bcd + 16'h1111;
      tick();
      check("bp_code", bus.out_code, 16'hFEDC);
      check("bp_valid", bus.out_valid, 1'b1);
      check("bp_in_ready", bus.in_ready, 1'b0);
    end
    bus.in_valid = 1'b0;
    drain();

    // Back-to-back with in_valid and out_ready both held high.
    bus.in_bcd    = 16'h0001;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 20 && acc_cyc.size() < 2; c++) begin
      fire = bus.in_valid & bus.in_ready;
      take = bus.out_valid & bus.out_ready;
      if (take) outs.push_back(bus.out_code);
      tick();
      if (fire) begin
        acc_cyc.push_back(c);
        bus.in_bcd = 16'h0009;
      end
    end
    bus.in_valid = 1'b0;
    for (int c = 0; c < 20 && outs.size() < 2; c++) begin
      take = bus.out_valid & bus.out_ready;
      if (take) outs.push_back(bus.out_code);
      tick();
    end
    bus.out_ready = 1'b0;
    check("b2b_accepts", acc_cyc.size(), 2);
    if (acc_cyc.size() == 2) check("b2b_period", acc_cyc[1] - acc_cyc[0], NDIG + 2);
    check("b2b_outs", outs.size(), 2);
    if (outs.size() == 2) begin
      check("b2b_out0", outs[0], 16'h0001);
      check("b2b_out1", outs[1], 16'h000F);
    end
    tick();

    run_word("w12A4", 16'h12A4, 16'h1204, exp_err_bad);
    run_word("w0000", 16'h0000, 16'h0000, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
